mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a single memory port, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is load/store priority with a fetch starvation limit.
module mem_arbiter #(
  parameter int XLEN          = 64,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic              if_valid,
  output logic              if_err,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [XLEN-1:0]   ls_wdata,
  input  logic [XLEN/8-1:0] ls_wstrb,
  output logic              ls_ready,
  output logic              ls_valid,
  output logic              ls_err,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_valid,
  input  logic              mem_err,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [2:0] {IDLE, GNT_IF, GNT_LS, WAIT_IF, WAIT_LS} state_t;

  state_t          state, state_nxt;
  logic            last_ls, last_ls_nxt;
  logic            killed, killed_nxt;
  logic [XLEN-1:0] if_rdata_q, ls_rdata_q;
  logic            resp, if_resp, ls_resp, pick_ls;

`ifdef MEM_ARB_RR_EN
  // On a conflict the side that did not win last time goes first.
  assign pick_ls = ls_req && (!if_req || !last_ls);
`else
  localparam int SW = $clog2(MAX_LS_STREAK + 1);

  logic [SW-1:0] ls_streak;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(MAX_LS_STREAK)) ? v : v + SW'(1);
  endfunction

  // Load/store wins conflicts until it has starved a waiting fetch MAX_LS_STREAK times in a row.
  assign pick_ls = ls_req && (!if_req || (ls_streak != SW'(MAX_LS_STREAK)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ls_streak <= '0;
    else if (state == IDLE)
      ls_streak <= (pick_ls && if_req) ? sat_inc(ls_streak) : '0;
  end
`endif

  always_comb begin
    state_nxt   = state;
    last_ls_nxt = last_ls;
    killed_nxt  = killed;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    if_ready    = 1'b0;
    ls_ready    = 1'b0;
    if_resp     = 1'b0;
    ls_resp     = 1'b0;
    resp        = mem_valid || mem_err;
    case (state)
      IDLE: begin
        killed_nxt = 1'b0;
        if (pick_ls) begin
          state_nxt   = GNT_LS;
          last_ls_nxt = 1'b1;
        end else if (if_req) begin
          state_nxt   = GNT_IF;
          last_ls_nxt = 1'b0;
        end
      end
      GNT_IF: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
        if_ready = mem_ready;
        if (mem_ready) begin
          state_nxt  = WAIT_IF;
          killed_nxt = if_kill;
        end else if (if_kill) begin
          state_nxt = IDLE;
        end
      end
      GNT_LS: begin
        mem_req   = 1'b1;
        mem_we    = ls_we;
        mem_addr  = ls_addr;
        mem_wdata = ls_wdata;
        mem_wstrb = ls_wstrb;
        ls_ready  = mem_ready;
        if (mem_ready) state_nxt = WAIT_LS;
      end
      WAIT_IF: begin
        // A killed fetch still drains its memory response, it is just not reported.
        if (resp) begin
          if_resp   = !(killed || if_kill);
          state_nxt = IDLE;
        end else if (if_kill) begin
          killed_nxt = 1'b1;
        end
      end
      WAIT_LS: begin
        if (resp) begin
          ls_resp   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_ls    <= 1'b1;
      killed     <= 1'b0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      last_ls <= last_ls_nxt;
      killed  <= killed_nxt;
      if (if_resp) if_rdata_q <= mem_rdata;
      if (ls_resp) ls_rdata_q <= mem_rdata;
    end
  end

  // Responses pass straight through in their cycle; read data holds afterwards.
  assign if_valid = if_resp;
  assign if_err   = if_resp && mem_err;
  assign if_rdata = if_resp ? mem_rdata : if_rdata_q;
  assign ls_valid = ls_resp;
  assign ls_err   = ls_resp && mem_err;
  assign ls_rdata = ls_resp ? mem_rdata : ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: memory responder model, per-port response scoreboard, directed and randomized traffic.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int XLEN = 64;
  localparam int SB   = XLEN / 8;
  localparam int MAXS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req, if_kill, if_ready, if_valid, if_err;
  logic [31:0]     if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req, ls_we, ls_ready, ls_valid, ls_err;
  logic [31:0]     ls_addr;
  logic [XLEN-1:0] ls_wdata, ls_rdata;
  logic [SB-1:0]   ls_wstrb;
  logic            mem_req, mem_we, mem_ready, mem_valid, mem_err;
  logic [31:0]     mem_addr;
  logic [XLEN-1:0] mem_wdata, mem_rdata;
  logic [SB-1:0]   mem_wstrb;

  mem_arbiter #(.XLEN(XLEN), .MAX_LS_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_ready(if_ready), .if_valid(if_valid), .if_err(if_err), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_err(ls_err), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_err(mem_err),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory contents and fault map seen by the bench's memory model.
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0072_6168_756C_2121;
    return {a ^ 32'hC3A5_5A3C, ~a};
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return a[7:4] == 4'hE;
  endfunction

  typedef struct packed {logic err; logic [63:0] data;} rsp_t;

  function automatic rsp_t mk_rsp(input logic [31:0] a);
    rsp_t r;
    r.err  = mem_fault(a);
    r.data = mem_word(a);
    return r;
  endfunction

  // Memory responder: accepts with probability rdy_pct, answers after lat_cfg cycles (0 = random 1..4).
  int          rdy_pct = 100;
  int          lat_cfg = 2;
  logic        mm_busy = 1'b0;
  int          mm_cnt  = 0;
  logic [31:0] mm_addr = '0;

  initial begin
    mem_ready = 1'b0; mem_valid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_ready && !reset) begin
        mm_busy = 1'b1;
        mm_addr = mem_addr;
        mm_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      end
      @(posedge clk); #1;
      mem_valid = 1'b0;
      mem_err   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (mm_busy) begin
        mm_cnt--;
        if (mm_cnt == 0) begin
          mm_busy   = 1'b0;
          mem_err   = mem_fault(mm_addr);
          mem_valid = !mem_err;
          mem_rdata = mem_word(mm_addr);
        end
      end
      mem_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Scoreboard monitor: pops expected responses per port whenever a response is presented.
  rsp_t        if_q[$], ls_q[$];
  rsp_t        if_e, ls_e;
  logic [63:0] if_last = '0, ls_last = '0;
  int          if_pulses = 0, ls_pulses = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("single_response", {63'd0, if_valid && ls_valid}, 64'd0);
      if (if_valid) begin
        if_pulses++;
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_unexpected_response actual=valid required=none");
        end else begin
          if_e = if_q.pop_front();
          chk("if_rdata", if_rdata, if_e.data);
          chk("if_err", {63'd0, if_err}, {63'd0, if_e.err});
          if_last = if_e.data;
        end
      end else begin
        chk("if_rdata_hold", if_rdata, if_last);
        chk("if_err_idle", {63'd0, if_err}, 64'd0);
      end
      if (ls_valid) begin
        ls_pulses++;
        if (ls_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ls_unexpected_response actual=valid required=none");
        end else begin
          ls_e = ls_q.pop_front();
          chk("ls_rdata", ls_rdata, ls_e.data);
          chk("ls_err", {63'd0, ls_err}, {63'd0, ls_e.err});
          ls_last = ls_e.data;
        end
      end else begin
        chk("ls_rdata_hold", ls_rdata, ls_last);
        chk("ls_err_idle", {63'd0, ls_err}, 64'd0);
      end
    end
  end

  // Requesters: called at posedge+1, return at posedge+1 after their handshake.
  int grant_log[$];
  int ls_run = 0;

  task automatic fetch_txn(input logic [31:0] a);
    int n = 0;
    if_req = 1'b1; if_addr = a;
    @(negedge clk);
    while (!if_ready && n < 300) begin n++; @(negedge clk); end
    checks++;
    if (!if_ready) begin
      errors++;
      $display("FAIL fetch_handshake_timeout actual=no_ready required=ready");
    end else begin
      chk("fetch_mem_addr", {32'd0, mem_addr}, {32'd0, a});
      chk("fetch_mem_we", {63'd0, mem_we}, 64'd0);
      chk("fetch_mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
      chk("fetch_ls_ready_low", {63'd0, ls_ready}, 64'd0);
      if_q.push_back(mk_rsp(a));
      grant_log.push_back(0);
      ls_run = 0;
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic ls_txn(input logic we, input logic [31:0] a, input logic [63:0] wd,
                        input logic [7:0] ws, input logic keep);
    int n = 0;
    ls_req = 1'b1; ls_we = we; ls_addr = a; ls_wdata = wd; ls_wstrb = ws;
    @(negedge clk);
    while (!ls_ready && n < 300) begin n++; @(negedge clk); end
    checks++;
    if (!ls_ready) begin
      errors++;
      $display("FAIL ls_handshake_timeout actual=no_ready required=ready");
    end else begin
      chk("ls_mem_addr", {32'd0, mem_addr}, {32'd0, a});
      chk("ls_mem_we", {63'd0, mem_we}, {63'd0, we});
      chk("ls_mem_wstrb", {56'd0, mem_wstrb}, {56'd0, ws});
      if (we) chk("ls_mem_wdata", mem_wdata, wd);
      chk("ls_if_ready_low", {63'd0, if_ready}, 64'd0);
      ls_q.push_back(mk_rsp(a));
      grant_log.push_back(1);
      if (if_req) begin
        ls_run++;
        chk("fetch_starvation_bound", {63'd0, ls_run > MAXS + 1}, 64'd0);
      end else begin
        ls_run = 0;
      end
    end
    @(posedge clk); #1;
    if (!keep) ls_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((if_q.size() != 0 || ls_q.size() != 0) && n < 500) begin n++; @(negedge clk); end
    chk("drain_pending", 64'(if_q.size() + ls_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int p0;
  int n0;
  int exp_order[6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_mem_we", {63'd0, mem_we}, 64'd0);
    chk("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("reset_if_outputs", {60'd0, if_ready, if_valid, if_err, 1'b0}, 64'd0);
    chk("reset_ls_outputs", {60'd0, ls_ready, ls_valid, ls_err, 1'b0}, 64'd0);
    chk("reset_if_rdata", if_rdata, 64'd0);
    chk("reset_ls_rdata", ls_rdata, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single fetch with a fixed two-cycle memory latency.
    if_req = 1'b1; if_addr = 32'h8000_0000;
    @(negedge clk);
    chk("fetch_arb_cycle_mem_req", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    chk("fetch_c1_if_ready", {63'd0, if_ready}, 64'd1);
    chk("fetch_c1_mem_req", {63'd0, mem_req}, 64'd1);
    chk("fetch_c1_mem_we", {63'd0, mem_we}, 64'd0);
    chk("fetch_c1_mem_addr", {32'd0, mem_addr}, 64'h8000_0000);
    if_q.push_back(mk_rsp(32'h8000_0000));
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_c2_no_valid", {63'd0, if_valid}, 64'd0);
    @(negedge clk);
    chk("fetch_c3_valid", {63'd0, if_valid}, 64'd1);
    chk("fetch_c3_rdata", if_rdata, 64'h0072_6168_756C_2121);
    @(negedge clk);
    chk("fetch_c4_valid_drop", {63'd0, if_valid}, 64'd0);
    drain();

    // Simultaneous requests from IDLE: store first, then fetch.
    grant_log.delete();
    fork
      fetch_txn(32'h0000_2000);
      ls_txn(1'b1, 32'h0000_3000, {$urandom, $urandom}, 8'hFF, 1'b0);
    join
    chk("conflict_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("conflict_first_ls", 64'(grant_log[0]), 64'd1);
      chk("conflict_second_if", 64'(grant_log[1]), 64'd0);
    end
    drain();

    // Back-to-back stores against a waiting fetch.
    grant_log.delete();
    fork
      fetch_txn(32'h0000_4000);
      for (int i = 0; i < 6; i++)
        ls_txn(1'b1, 32'h0000_5000 + 32'(i * 8), {$urandom, $urandom}, 8'(i + 1), i < 5);
    join
    chk("starve_grant_count", 64'(grant_log.size()), 64'd7);
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) chk("starve_grant_order", 64'(grant_log[i]), 64'(exp_order[i]));
    drain();

    // Kill while granted but not yet accepted.
    rdy_pct = 0;
    repeat (2) @(posedge clk);
    #1;
    p0 = if_pulses;
    if_req = 1'b1; if_addr = 32'h0000_6000;
    @(posedge clk); #1;
    if_kill = 1'b1;
    @(negedge clk);
    chk("kill_gnt_if_ready", {63'd0, if_ready}, 64'd0);
    @(posedge clk); #1;
    if_req = 1'b0; if_kill = 1'b0;
    @(negedge clk);
    chk("kill_gnt_mem_req_dropped", {63'd0, mem_req}, 64'd0);
    chk("kill_gnt_if_ready_after", {63'd0, if_ready}, 64'd0);
    rdy_pct = 100;
    repeat (6) @(negedge clk);
    chk("kill_gnt_no_response", 64'(if_pulses - p0), 64'd0);
    @(posedge clk); #1;

    // Kill while waiting on memory.
    lat_cfg = 3;
    p0 = if_pulses;
    if_req = 1'b1; if_addr = 32'h0000_7000;
    n0 = 0;
    @(negedge clk);
    while (!if_ready && n0 < 50) begin n0++; @(negedge clk); end
    chk("kill_wait_handshake", {63'd0, if_ready}, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_kill = 1'b1;
    @(posedge clk); #1;
    if_kill = 1'b0;
    repeat (6) @(negedge clk);
    chk("kill_wait_no_response", 64'(if_pulses - p0), 64'd0);
    @(posedge clk); #1;

    // Kill coincident with acceptance: transaction completes, response suppressed.
    p0 = if_pulses;
    if_req = 1'b1; if_addr = 32'h0000_7100;
    @(posedge clk); #1;
    if_kill = 1'b1;
    @(negedge clk);
    chk("kill_accept_if_ready", {63'd0, if_ready}, 64'd1);
    @(posedge clk); #1;
    if_req = 1'b0; if_kill = 1'b0;
    repeat (6) @(negedge clk);
    chk("kill_accept_no_response", 64'(if_pulses - p0), 64'd0);
    @(posedge clk); #1;
    fetch_txn(32'h0000_7200);
    drain();

    // Load that returns a memory error.
    ls_txn(1'b0, 32'h0000_10E0, 64'd0, 8'h00, 1'b0);
    n0 = 0;
    while (!ls_valid && n0 < 50) begin n0++; @(negedge clk); end
    chk("err_ls_valid", {63'd0, ls_valid}, 64'd1);
    chk("err_ls_err", {63'd0, ls_err}, 64'd1);
    @(negedge clk);
    chk("err_valid_one_cycle", {62'd0, ls_valid, ls_err}, 64'd0);
    chk("err_back_idle", {63'd0, mem_req}, 64'd0);
    drain();

    // Reset in the middle of a load's wait.
    lat_cfg = 5;
    ls_txn(1'b0, 32'h0000_9000, 64'd0, 8'h00, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    if_last = '0; ls_last = '0;
    ls_q.delete();
    p0 = ls_pulses;
    #1;
    chk("midreset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("midreset_ls_valid", {63'd0, ls_valid}, 64'd0);
    chk("midreset_ls_rdata", ls_rdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midreset_late_response_ignored", 64'(ls_pulses - p0), 64'd0);
    @(posedge clk); #1;
    lat_cfg = 2;
    drain();

    // Randomized concurrent traffic.
    rdy_pct = 60;
    lat_cfg = 0;
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        fetch_txn($urandom & 32'hFFFF_FFF8);
      end
      for (int j = 0; j < 40; j++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        ls_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF8, {$urandom, $urandom},
               8'($urandom_range(0, 255)), 1'b0);
      end
    join
    drain();
    rdy_pct = 100;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
